// File: rtl/hamming7_encode_tx.sv
// Hamming(7,4) encoder with framed serial transmit and one-entry holding buffer.
// Optional error injection (ERRPOS input) enabled by HAMMING7_ERR_INJECT_EN.
module hamming7_encode_tx #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic       dvalid,
`ifdef HAMMING7_ERR_INJECT_EN
  input  logic [2:0] errpos,
`endif
  output logic       dready,
  output logic       txd,
  output logic       txbusy,
  output logic [7:1] cw,
  output logic       cwvalid
);

  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bitidx, bitidx_n;
  logic [6:0]       sh, sh_n;
  logic             txd_n;
  logic             hold_full;
  logic [3:0]       hold_nib;
  logic             accept;
  logic             launch;
  logic             slot_end;
  logic [7:1]       enc;
`ifdef HAMMING7_ERR_INJECT_EN
  logic [2:0]       hold_ep;
`endif

  assign dready   = ~hold_full;
  assign accept   = dvalid & ~hold_full;
  assign txbusy   = (state != IDLE);
  assign slot_end = (cnt == SLOT_LAST);

  always_comb begin
    enc    = '0;
    enc[7] = hold_nib[3];
    enc[6] = hold_nib[2];
    enc[5] = hold_nib[1];
    enc[3] = hold_nib[0];
    enc[4] = enc[7] ^ enc[6] ^ enc[5];
    enc[2] = enc[7] ^ enc[6] ^ enc[3];
    enc[1] = enc[7] ^ enc[5] ^ enc[3];
`ifdef HAMMING7_ERR_INJECT_EN
    // position 0 means "no flip"; 1..7 address the codeword directly
    if (hold_ep != 3'd0) enc[hold_ep] = ~enc[hold_ep];
`endif
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitidx_n = bitidx;
    sh_n     = sh;
    txd_n    = txd;
    launch   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) launch = 1'b1;
      end
      START: begin
        if (slot_end) begin
          state_n  = DATA;
          cnt_n    = '0;
          bitidx_n = '0;
          txd_n    = sh[6];
          sh_n     = {sh[5:0], 1'b0};
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (slot_end) begin
          cnt_n = '0;
          if (bitidx == 3'd6) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bitidx_n = bitidx + 3'd1;
            txd_n    = sh[6];
            sh_n     = {sh[5:0], 1'b0};
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (slot_end) begin
          cnt_n = '0;
          if (hold_full) launch = 1'b1;
          else state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      state_n = START;
      cnt_n   = '0;
      sh_n    = enc;
      txd_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      sh        <= '0;
      txd       <= 1'b1;
      cw        <= '0;
      cwvalid   <= 1'b0;
      hold_full <= 1'b0;
      hold_nib  <= '0;
`ifdef HAMMING7_ERR_INJECT_EN
      hold_ep   <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitidx  <= bitidx_n;
      sh      <= sh_n;
      txd     <= txd_n;
      cwvalid <= launch;
      if (launch) cw <= enc;
      if (launch) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_nib  <= data;
`ifdef HAMMING7_ERR_INJECT_EN
        hold_ep   <= errpos;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hamming7_encode_tx.sv
// Scoreboard bench for hamming7_encode_tx: random nibbles vs. a parity model.
// Error-injection cases run only when HAMMING7_ERR_INJECT_EN is defined.
module tb_hamming7_encode_tx;
  localparam int BC = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic       dvalid;
  logic [2:0] errpos;
  logic       dready;
  logic       txd;
  logic       txbusy;
  logic [7:1] cw;
  logic       cwvalid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int launch_cyc = 0;
  int launches = 0;
  int run = 0;
  int last_run = 0;
  logic [7:1] q[$];

  hamming7_encode_tx #(.BIT_CYCLES(BC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .dvalid  (dvalid),
`ifdef HAMMING7_ERR_INJECT_EN
    .errpos  (errpos),
`endif
    .dready  (dready),
    .txd     (txd),
    .txbusy  (txbusy),
    .cw      (cw),
    .cwvalid (cwvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Hamming positions: data at 3,5,6,7; parity p covers positions j with j&p.
  function automatic logic [7:1] ref_cw(input logic [3:0] d, input int ep);
    logic [7:1] c;
    int dpos[4];
    logic par;
    dpos = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[dpos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (j != p && (j & p) != 0) par = par ^ c[j];
      c[p] = par;
    end
    if (ep != 0) c[ep] = ~c[ep];
    return c;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) run = 0;
    else if (txbusy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  // Monitor: one frame per CWVALID pulse, sampled every clock
  initial begin : monitor
    logic [7:1] exp;
    logic [8:0] frame;
    logic       cur;
    bit         stable;
    bit         busy_ok;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && cwvalid) begin
        launch_cyc = cyc;
        exp = '0;
        if (q.size() == 0) chk("unexpected_frame", 1, 0);
        else exp = q.pop_front();
        chk("cw", {25'd0, cw}, {25'd0, exp});
        frame = '0;
        cur = 1'b0;
        stable = 1'b1;
        busy_ok = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 9 * BC; k++) begin
          if (k != 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (k == 1) chk("cwvalid_pulse", {31'd0, cwvalid}, 0);
          if (k % BC == 0) begin
            cur = txd;
            frame = {frame[7:0], txd};
          end else if (txd !== cur) begin
            stable = 1'b0;
          end
          if (!txbusy) busy_ok = 1'b0;
        end
        if (!aborted) begin
          launches++;
          chk("serial_frame", {23'd0, frame}, {23'd0, 1'b0, exp, 1'b1});
          chk("slot_stable", {31'd0, stable}, 1);
          chk("busy_in_frame", {31'd0, busy_ok}, 1);
        end
      end
    end
  end

  task automatic send(input logic [3:0] nib, input int ep,
                      input logic [7:1] exp, output int waits);
    data = nib;
    errpos = ep[2:0];
    dvalid = 1'b1;
    waits = 0;
    while (!dready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (!dready) begin
      chk("accept_timeout", 1, 0);
    end else begin
      q.push_back(exp);
      accept_cyc = cyc + 1;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((txbusy || !dready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {30'd0, txbusy, dready}, 1);
    @(negedge clk);
  endtask

  initial begin : driver
    int w;
    logic [3:0] nib;
    int ep;
    rst_n = 1'b0;
    dvalid = 1'b0;
    data = '0;
    errpos = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 1);
    chk("rst_busy", {31'd0, txbusy}, 0);
    chk("rst_dready", {31'd0, dready}, 1);
    chk("rst_cw", {25'd0, cw}, 0);
    chk("rst_cwvalid", {31'd0, cwvalid}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_txd", {31'd0, txd}, 1);
      chk("idle_dready", {31'd0, dready}, 1);
      chk("idle_busy", {31'd0, txbusy}, 0);
      chk("idle_cw", {25'd0, cw}, 0);
    end

    send(4'b1011, 0, 7'b1010101, w);
    dvalid = 1'b0;
    wait_idle();
    chk("latency", launch_cyc - accept_cyc, 1);
    chk("single_frame_len", last_run, 36);

    send(4'h0, 0, 7'b0000000, w);
    dvalid = 1'b0;
    wait_idle();
    send(4'hF, 0, 7'b1111111, w);
    dvalid = 1'b0;
    wait_idle();
    send(4'h1, 0, 7'b0000111, w);
    dvalid = 1'b0;
    wait_idle();

    send(4'h5, 0, ref_cw(4'h5, 0), w);
    send(4'hA, 0, ref_cw(4'hA, 0), w);
    chk("second_accept_wait", w, 1);
    send(4'h3, 0, ref_cw(4'h3, 0), w);
    chk("third_accept_wait", w, 9 * BC - 1);
    dvalid = 1'b0;
    wait_idle();
    chk("b2b_busy_len", last_run, 27 * BC);

    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      send(nib, 0, ref_cw(nib, 0), w);
    end
    dvalid = 1'b0;
    wait_idle();
    chk("all16_busy_len", last_run, 16 * 9 * BC);

    for (int i = 0; i < 20; i++) begin
      nib = 4'($urandom_range(0, 15));
`ifdef HAMMING7_ERR_INJECT_EN
      ep = int'($urandom_range(0, 7));
`else
      ep = 0;
`endif
      send(nib, ep, ref_cw(nib, ep), w);
      dvalid = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle();

`ifdef HAMMING7_ERR_INJECT_EN
    send(4'b1011, 3, 7'b1010001, w);
    dvalid = 1'b0;
    wait_idle();
    send(4'b1011, 0, 7'b1010101, w);
    dvalid = 1'b0;
    wait_idle();
`endif

    send(4'h6, 0, ref_cw(4'h6, 0), w);
    send(4'h9, 0, ref_cw(4'h9, 0), w);
    dvalid = 1'b0;
    repeat (3 * BC + 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_txd", {31'd0, txd}, 1);
    chk("midrst_dready", {31'd0, dready}, 1);
    chk("midrst_cw", {25'd0, cw}, 0);
    chk("midrst_busy", {31'd0, txbusy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    w = launches;
    repeat (60) @(negedge clk);
    chk("no_frame_after_rst", launches, w);
    chk("post_rst_txd", {31'd0, txd}, 1);
    chk("post_rst_busy", {31'd0, txbusy}, 0);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
